carry_stim_seq: RTL and testbench



---
 rtl/carry_stim_seq.sv | 181 ++++++++++++++++++
 tb/tb_carry_stim_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carry_stim_seq.sv
// Carry-chain minitest stimulus/readback sequencer for the serial harness.
// Optional self-check (err_count, pass) enabled by CARRY_STIM_CHECK_EN.
module carry_stim_seq #(
  parameter int DIN_N   = 256,
  parameter int DOUT_N  = 256,
  parameter int VEC_W   = 2,
  parameter int RES_BIT = 0
`ifdef CARRY_STIM_CHECK_EN
  ,
  parameter logic [2**VEC_W-1:0] EXP_MASK = 4'b1100
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               di,
  output logic               stb,
  input  logic               do_in,
  output logic               busy,
  output logic               done,
  output logic [2**VEC_W-1:0] results
`ifdef CARRY_STIM_CHECK_EN
  ,
  output logic [VEC_W:0]     err_count,
  output logic               pass
`endif
);

  localparam int NVEC = 2**VEC_W;
  localparam int F_W  = $clog2(NVEC + 2);
  localparam int K_W  = (DIN_N > 2) ? $clog2(DIN_N) : 1;
  localparam int E_W  = VEC_W + 1;

  localparam logic [F_W-1:0] F_NVEC = F_W'(NVEC);
  localparam logic [F_W-1:0] F_LAST = F_W'(NVEC + 1);
  localparam logic [F_W-1:0] F_CAP0 = F_W'(2);
  localparam logic [K_W-1:0] K_LAST = K_W'(DIN_N - 1);
  localparam logic [K_W-1:0] K_CAP  = K_W'(DOUT_N - 1 - RES_BIT);
  localparam logic [K_W-1:0] K_VEC  = K_W'(VEC_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_STB
  } state_t;

  state_t            state_q, state_d;
  logic [F_W-1:0]    f_q, f_d;
  logic [K_W-1:0]    k_q, k_d;
  logic              di_q, di_d;
  logic              stb_q, stb_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NVEC-1:0]   results_q, results_d;
  logic [VEC_W-1:0]  vidx;
  logic              cap;
`ifdef CARRY_STIM_CHECK_EN
  localparam logic [E_W-1:0] E_SAT = E_W'(NVEC);
  logic [E_W-1:0]    err_q, err_d;
  logic              pass_q, pass_d;
`endif

  // Bit shifted out at cycle k of frame f; frames are sent MSB first.
  function automatic logic frame_bit(
    input logic [F_W-1:0] f,
    input logic [K_W-1:0] k
  );
    logic [K_W-1:0] ix;
    logic [F_W-1:0] sh;
    ix = K_LAST - k;
    sh = f >> ix;
    frame_bit = (f < F_NVEC) && (ix < K_VEC) && sh[0];
  endfunction

  always_comb begin
    state_d   = state_q;
    f_d       = f_q;
    k_d       = k_q;
    di_d      = 1'b0;
    stb_d     = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    results_d = results_q;
    vidx      = VEC_W'(f_q - F_CAP0);
    cap       = (state_q == S_SHIFT) && (f_q >= F_CAP0) &&
                (k_q == K_CAP);
`ifdef CARRY_STIM_CHECK_EN
    err_d  = err_q;
    pass_d = pass_q;
`endif
    if (cap) begin
      results_d[vidx] = do_in;
`ifdef CARRY_STIM_CHECK_EN
      if ((do_in != EXP_MASK[vidx]) && (err_q != E_SAT))
        err_d = err_q + 1'b1;
`endif
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SHIFT;
          f_d       = '0;
          k_d       = '0;
          busy_d    = 1'b1;
          results_d = '0;
          di_d      = frame_bit('0, '0);
`ifdef CARRY_STIM_CHECK_EN
          err_d     = '0;
          pass_d    = 1'b0;
`endif
        end
      end
      S_SHIFT: begin
        if (k_q == K_LAST) begin
          state_d = S_STB;
          stb_d   = 1'b1;
        end else begin
          k_d  = k_q + 1'b1;
          di_d = frame_bit(f_q, k_q + 1'b1);
        end
      end
      S_STB: begin
        if (f_q == F_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef CARRY_STIM_CHECK_EN
          pass_d  = (err_q == '0);
`endif
        end else begin
          state_d = S_SHIFT;
          f_d     = f_q + 1'b1;
          k_d     = '0;
          di_d    = frame_bit(f_q + 1'b1, '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      f_q       <= '0;
      k_q       <= '0;
      di_q      <= 1'b0;
      stb_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      results_q <= '0;
`ifdef CARRY_STIM_CHECK_EN
      err_q     <= '0;
      pass_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      f_q       <= f_d;
      k_q       <= k_d;
      di_q      <= di_d;
      stb_q     <= stb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      results_q <= results_d;
`ifdef CARRY_STIM_CHECK_EN
      err_q     <= err_d;
      pass_q    <= pass_d;
`endif
    end
  end

  assign di      = di_q;
  assign stb     = stb_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign results = results_q;
`ifdef CARRY_STIM_CHECK_EN
  assign err_count = err_q;
  assign pass      = pass_q;
`endif

endmodule

// File: tb/tb_carry_stim_seq.sv
// Bench for carry_stim_seq: harness models with table-driven ROI functions.
// Covers default and 8-bit frame instances; CARRY_STIM_CHECK_EN aware.
module tb_carry_stim_seq;

  logic       clk = 1'b0;
  logic       rst, start, start2;
  logic       di, stb, do_in, busy, done;
  logic [3:0] results;
  logic       di2, stb2, do2, busy2, done2;
  logic [3:0] results2;
`ifdef CARRY_STIM_CHECK_EN
  localparam logic [3:0] EXP = 4'b1100;
  logic [2:0] err_count, err2;
  logic       pass, pass2;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  carry_stim_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .di(di), .stb(stb), .do_in(do_in),
    .busy(busy), .done(done), .results(results)
`ifdef CARRY_STIM_CHECK_EN
    , .err_count(err_count), .pass(pass)
`endif
  );

  carry_stim_seq #(
    .DIN_N(8), .DOUT_N(8), .VEC_W(2), .RES_BIT(3)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .di(di2), .stb(stb2), .do_in(do2),
    .busy(busy2), .done(done2), .results(results2)
`ifdef CARRY_STIM_CHECK_EN
    , .err_count(err2), .pass(pass2)
`endif
  );

  // Harness model, 256-bit: ROI drives dout[0] = lut[din[1:0]], rest inverted
  logic [3:0]   lut;
  logic [255:0] h1_shr, h1_din, h1_dsh;

  function automatic logic [255:0] roi1(
    input logic [255:0] d, input logic [3:0] t);
    logic b;
    b = t[d[1:0]];
    roi1 = {256{~b}};
    roi1[0] = b;
  endfunction

  always @(posedge clk) begin
    h1_shr <= {h1_shr[254:0], di};
    if (stb) begin
      h1_din <= h1_shr;
      h1_dsh <= roi1(h1_din, lut);
    end else begin
      h1_dsh <= {h1_dsh[254:0], h1_shr[255]};
    end
  end
  assign do_in = h1_dsh[255];

  // Harness model, 8-bit: dout[3] = din[0], other bits inverted
  logic [7:0] h2_shr, h2_din, h2_dsh;

  function automatic logic [7:0] roi2(input logic [7:0] d);
    roi2 = {8{~d[0]}};
    roi2[3] = d[0];
  endfunction

  always @(posedge clk) begin
    h2_shr <= {h2_shr[6:0], di2};
    if (stb2) begin
      h2_din <= h2_shr;
      h2_dsh <= roi2(h2_din);
    end else begin
      h2_dsh <= {h2_dsh[6:0], h2_shr[7]};
    end
  end
  assign do2 = h2_dsh[7];

  // Strobe monitor: cycle of each pulse and din loaded by it
  int         stb_cyc[$];
  logic [1:0] stb_din[$];
  int         stb_dbl = 0;
  bit         stb_prev = 0;
  bit         ld_pend = 0;

  always @(negedge clk) begin
    if (ld_pend) stb_din.push_back(h1_din[1:0]);
    ld_pend = stb;
    if (stb) begin
      stb_cyc.push_back(cyc);
      if (stb_prev) stb_dbl++;
    end
    stb_prev = stb;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sweep(input logic [3:0] t, input string tag);
    int t0, t1;
    bit ok;
    lut = t;
    stb_cyc.delete();
    stb_din.delete();
    stb_dbl = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 1);
    check({tag, "_clr"}, 32'(results), 0);
    t0 = cyc;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
    t1 = cyc;
    check({tag, "_done_seen"}, 32'(ok), 1);
    check({tag, "_len"}, 32'(t1 - t0), 1542);
    check({tag, "_busy_low"}, 32'(busy), 0);
    check({tag, "_results"}, 32'(results), 32'(t));
`ifdef CARRY_STIM_CHECK_EN
    check({tag, "_err"}, 32'(err_count), $countones(t ^ EXP));
    check({tag, "_pass"}, 32'(pass), 32'((t ^ EXP) == 4'b0));
`endif
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_hold"}, 32'(results), 32'(t));
    @(negedge clk);
    check({tag, "_stb_n"}, 32'(stb_cyc.size()), 6);
    check({tag, "_stb_dbl"}, 32'(stb_dbl), 0);
    if (stb_cyc.size() == 6 && stb_din.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("%s_stb_at%0d", tag, i),
              32'(stb_cyc[i] - t0), 32'(256 + 257 * i));
        check($sformatf("%s_din%0d", tag, i),
              32'(stb_din[i]), (i < 4) ? i : 0);
      end
    end
  endtask

  initial begin
    int t0, t1, nd;
    bit ok;
    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    lut = 4'b1100;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_outs", 32'({di, stb, busy, done, results}), 0);
    check("rst_outs2", 32'({di2, stb2, busy2, done2, results2}), 0);
`ifdef CARRY_STIM_CHECK_EN
    check("rst_chk", 32'({err_count, pass}), 0);
`endif
    @(negedge clk);

    sweep(4'b1100, "roi_s0");
    sweep(4'b1010, "roi_ci");
    for (int r = 0; r < 3; r++)
      sweep(4'($urandom_range(0, 15)), $sformatf("rnd%0d", r));

    // Mid-sweep reset
    lut = 4'b1100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (699) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_outs", 32'({di, stb, busy, done, results}), 0);
`ifdef CARRY_STIM_CHECK_EN
    check("midrst_chk", 32'({err_count, pass}), 0);
`endif
    nd = 0;
    repeat (1600) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("midrst_no_done", 32'(nd), 0);
    sweep(4'b1100, "after_rst");

    // start during a sweep is ignored
    lut = 4'b0110;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    t1 = 0;
    nd = 0;
    for (int i = 0; i < 2000; i++) begin
      start = (cyc - t0 == 10) || (cyc - t0 == 1000);
      @(negedge clk);
      if (done) begin
        nd++;
        if (t1 == 0) t1 = cyc;
      end
    end
    start = 1'b0;
    check("ign_ndone", 32'(nd), 1);
    check("ign_len", 32'(t1 - t0), 1542);
    check("ign_results", 32'(results), 32'(4'b0110));

    // start accepted in the done cycle
    lut = 4'b1001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
    check("dc_first_done", 32'(ok), 1);
    check("dc_first_res", 32'(results), 32'(4'b1001));
    lut = 4'b0011;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("dc_restart_busy", 32'(busy), 1);
    check("dc_restart_clr", 32'(results), 0);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
    check("dc_second_done", 32'(ok), 1);
    check("dc_second_res", 32'(results), 32'(4'b0011));

    // 8-bit frame instance
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("small_busy", 32'(busy2), 1);
    t0 = cyc;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done2) begin
        ok = 1;
        break;
      end
    end
    t1 = cyc;
    check("small_done_seen", 32'(ok), 1);
    check("small_len", 32'(t1 - t0), 54);
    check("small_results", 32'(results2), 32'(4'b1010));
`ifdef CARRY_STIM_CHECK_EN
    check("small_err", 32'(err2), $countones(4'b1010 ^ EXP));
    check("small_pass", 32'(pass2), 0);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
